// File: rtl/anti_bounce_pkg.sv
// Shared constants and types for the anti_bounce_bank debouncer.
//
// Contents:
//   StableTicksDefault - default tick_mf pulses a new level must persist before acceptance
//   LongTicksDefault   - default tick_mf pulses a press must persist before long_press
//   chan_state_e       - per-channel debounce state (StStable, StPending)
package anti_bounce_pkg;

    localparam int unsigned StableTicksDefault = 20;
    localparam int unsigned LongTicksDefault   = 1000;

    typedef enum logic {
        StStable  = 1'b0,
        StPending = 1'b1
    } chan_state_e;

endpackage

// File: rtl/anti_bounce_bank_if.sv
// Button-bank signal bundle shared between the debouncer and its user.
//
// Signals (N_CH wide unless noted):
//   tick_mf       - 1 bit, one-clk enable pulse; the only time base for the counters
//   btn_in        - raw asynchronous button levels, active-high
//   btn_out       - debounced levels
//   press         - one-clk pulse on an accepted 0->1 transition
//   release_pulse - one-clk pulse on an accepted 1->0 transition ('release' is an SV keyword)
//   long_press    - one-clk pulse on a long hold (always 0 unless ANTI_BOUNCE_LONG_PRESS_EN)
//
// Modports: master drives tick_mf/btn_in, slave (the debouncer) drives the rest.
interface anti_bounce_bank_if #(
    parameter int unsigned N_CH = 4
);

    logic            tick_mf;
    logic [N_CH-1:0] btn_in;
    logic [N_CH-1:0] btn_out;
    logic [N_CH-1:0] press;
    logic [N_CH-1:0] release_pulse;
    logic [N_CH-1:0] long_press;

    modport master (
        output tick_mf,
        output btn_in,
        input  btn_out,
        input  press,
        input  release_pulse,
        input  long_press
    );

    modport slave (
        input  tick_mf,
        input  btn_in,
        output btn_out,
        output press,
        output release_pulse,
        output long_press
    );

endinterface

// File: rtl/anti_bounce_chan.sv
// One debounce channel: 2-flop synchroniser, STABLE/PENDING FSM with tick-driven
// debounce counter, and (with ANTI_BOUNCE_LONG_PRESS_EN defined) a saturating hold
// counter that produces a single long_press pulse per press.
//
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   tick_mf       - counter enable pulse
//   btn_in        - raw asynchronous button level
//   btn_out       - registered debounced level
//   press         - one-clk pulse coincident with btn_out rising
//   release_pulse - one-clk pulse coincident with btn_out falling
//   long_press    - one-clk pulse after LONG_TICKS ticks of btn_out=1 (0 without the macro)
//
// Macro: ANTI_BOUNCE_LONG_PRESS_EN enables the hold counter and the LONG_TICKS parameter.
module anti_bounce_chan
    import anti_bounce_pkg::*;
#(
    parameter int unsigned STABLE_TICKS = StableTicksDefault
`ifdef ANTI_BOUNCE_LONG_PRESS_EN
    ,
    parameter int unsigned LONG_TICKS   = LongTicksDefault
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_mf,
    input  logic btn_in,
    output logic btn_out,
    output logic press,
    output logic release_pulse,
    output logic long_press
);

    localparam int unsigned     CntW   = $clog2(STABLE_TICKS);
    localparam logic [CntW-1:0] CntMax = CntW'(STABLE_TICKS - 1);

    logic [1:0]      sync_q;
    logic            sync;
    chan_state_e     state_q;
    logic [CntW-1:0] cnt_q;
    logic            btn_q;
    logic            press_q;
    logic            release_q;

    assign sync = sync_q[1];

    // Acceptance happens on the tick where cnt_q == STABLE_TICKS-1, so cnt_q never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= 2'b00;
            state_q   <= StStable;
            cnt_q     <= '0;
            btn_q     <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], btn_in};
            press_q   <= 1'b0;
            release_q <= 1'b0;
            unique case (state_q)
                StStable: begin
                    cnt_q <= '0;
                    if (sync != btn_q) begin
                        state_q <= StPending;
                    end
                end
                StPending: begin
                    if (sync == btn_q) begin
                        // Glitch rejected: drop progress, outputs untouched.
                        state_q <= StStable;
                        cnt_q   <= '0;
                    end else if (tick_mf) begin
                        if (cnt_q == CntMax) begin
                            btn_q     <= sync;
                            press_q   <= sync;
                            release_q <= ~sync;
                            cnt_q     <= '0;
                            state_q   <= StStable;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign btn_out       = btn_q;
    assign press         = press_q;
    assign release_pulse = release_q;

`ifdef ANTI_BOUNCE_LONG_PRESS_EN
    localparam int unsigned      HoldW   = $clog2(LONG_TICKS + 1);
    localparam logic [HoldW-1:0] HoldMax = HoldW'(LONG_TICKS);

    logic [HoldW-1:0] hold_q;
    logic             long_q;

    // Saturating at HoldMax is what limits long_press to one pulse per press.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            long_q <= 1'b0;
            if (!btn_q) begin
                hold_q <= '0;
            end else if (tick_mf && (hold_q != HoldMax)) begin
                hold_q <= hold_q + 1'b1;
                long_q <= (hold_q == HoldMax - 1'b1);
            end
        end
    end

    assign long_press = long_q;
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: rtl/anti_bounce_bank.sv
// Bank of N_CH independent button debouncers sharing one tick_mf time base.
//
// Ports:
//   clk - clock, all flops on its rising edge
//   rst - synchronous active-high reset
//   bus - anti_bounce_bank_if.slave: tick_mf, btn_in in; btn_out, press,
//         release_pulse, long_press out (all N_CH wide except tick_mf)
//
// Macro: ANTI_BOUNCE_LONG_PRESS_EN enables per-channel long_press generation;
// without it long_press is tied to 0.
module anti_bounce_bank
    import anti_bounce_pkg::*;
#(
    parameter int unsigned N_CH         = 4,
    parameter int unsigned STABLE_TICKS = StableTicksDefault,
    parameter int unsigned LONG_TICKS   = LongTicksDefault
) (
    input  logic               clk,
    input  logic               rst,
    anti_bounce_bank_if.slave  bus
);

    // Reject illegal configurations at elaboration.
    if ((N_CH < 1) || (N_CH > 32) || (STABLE_TICKS < 2) || (STABLE_TICKS > 65535) ||
        (LONG_TICKS <= STABLE_TICKS)) begin : g_bad_cfg
        $error("anti_bounce_bank: illegal N_CH/STABLE_TICKS/LONG_TICKS");
    end

    logic [N_CH-1:0] btn_out_v;
    logic [N_CH-1:0] press_v;
    logic [N_CH-1:0] release_v;
    logic [N_CH-1:0] long_v;

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        anti_bounce_chan #(
            .STABLE_TICKS (STABLE_TICKS)
`ifdef ANTI_BOUNCE_LONG_PRESS_EN
            ,
            .LONG_TICKS   (LONG_TICKS)
`endif
        ) u_chan (
            .clk           (clk),
            .rst           (rst),
            .tick_mf       (bus.tick_mf),
            .btn_in        (bus.btn_in[i]),
            .btn_out       (btn_out_v[i]),
            .press         (press_v[i]),
            .release_pulse (release_v[i]),
            .long_press    (long_v[i])
        );
    end

    assign bus.btn_out       = btn_out_v;
    assign bus.press         = press_v;
    assign bus.release_pulse = release_v;
    assign bus.long_press    = long_v;

endmodule

// File: tb/tb_anti_bounce_bank.sv
// Self-checking bench for anti_bounce_bank (N_CH=4, STABLE_TICKS=4, LONG_TICKS=10).
// tick_mf is generated here on every second clock, as a divide-by-2 freq_divider would.
// The reference model works from recorded input/tick history: a level is accepted on
// the STABLE_TICKS-th tick after it has been visible on the synchronised input
// (btn_in delayed two clocks) for one full clock without interruption; long_press fires
// on the LONG_TICKS-th tick after the press while the button is still accepted as down.
`timescale 1ns/1ps
module tb_anti_bounce_bank;

    localparam int unsigned N_CH = 4;
    localparam int unsigned ST   = 4;
    localparam int unsigned LT   = 10;
    localparam int          MAXC = 8192;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    anti_bounce_bank_if #(.N_CH(N_CH)) bus ();

    anti_bounce_bank #(
        .N_CH         (N_CH),
        .STABLE_TICKS (ST),
        .LONG_TICKS   (LT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state and history.
    logic [N_CH-1:0] btn_hist [MAXC];
    bit              tick_hist [MAXC];
    int              cyc      = 0;
    int              last_rst = 0;
    int              since      [N_CH];
    int              press_edge [N_CH];
    logic [N_CH-1:0] out_m;

    // Observed-event statistics for scenario checks.
    int press_cnt [N_CH];
    int rel_cnt   [N_CH];
    int long_cnt  [N_CH];
    int hi_cnt    [N_CH];
    int last_press_cyc [N_CH];
    int last_long_cyc  [N_CH];
    bit saw_all_press = 1'b0;
    bit saw_all_rel   = 1'b0;

    function automatic int ticks_in(int lo, int hi);
        int n = 0;
        for (int c = lo; c <= hi; c++) n += int'(tick_hist[c]);
        return n;
    endfunction

    task automatic chk(string tag, logic [N_CH-1:0] obs, logic [N_CH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_int(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    // One clock: predict the edge from pre-edge inputs, apply it, compare all outputs.
    task automatic cycle();
        logic [N_CH-1:0] e_press, e_rel, e_long;
        logic s;
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC);
            $fatal(1, "cycle budget exhausted");
        end
        bus.tick_mf    = (cyc % 2 == 1);
        btn_hist[cyc]  = bus.btn_in;
        tick_hist[cyc] = bus.tick_mf;
        e_press = '0;
        e_rel   = '0;
        e_long  = '0;
        if (rst) begin
            out_m    = '0;
            last_rst = cyc;
            for (int ch = 0; ch < N_CH; ch++) begin
                since[ch]      = -1;
                press_edge[ch] = -1;
            end
        end else begin
            for (int ch = 0; ch < N_CH; ch++) begin
                s = (cyc - 2 > last_rst) ? btn_hist[cyc-2][ch] : 1'b0;
`ifdef ANTI_BOUNCE_LONG_PRESS_EN
                if (out_m[ch] && tick_hist[cyc] && press_edge[ch] >= 0 &&
                    ticks_in(press_edge[ch] + 1, cyc) == LT) e_long[ch] = 1'b1;
`endif
                if (s == out_m[ch]) begin
                    since[ch] = -1;
                end else if (since[ch] < 0) begin
                    since[ch] = cyc;
                end else if (tick_hist[cyc] && ticks_in(since[ch] + 1, cyc) == ST) begin
                    out_m[ch]      = s;
                    e_press[ch]    = s;
                    e_rel[ch]      = ~s;
                    since[ch]      = -1;
                    press_edge[ch] = s ? cyc : -1;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("btn_out", bus.btn_out, out_m);
        chk("press", bus.press, e_press);
        chk("release", bus.release_pulse, e_rel);
        chk("long_press", bus.long_press, e_long);
        for (int ch = 0; ch < N_CH; ch++) begin
            if (bus.press[ch]) begin
                press_cnt[ch]++;
                last_press_cyc[ch] = cyc;
            end
            if (bus.release_pulse[ch]) rel_cnt[ch]++;
            if (bus.long_press[ch]) begin
                long_cnt[ch]++;
                last_long_cyc[ch] = cyc;
            end
            if (bus.btn_out[ch]) hi_cnt[ch]++;
        end
        if (bus.press == 4'b1111) saw_all_press = 1'b1;
        if (bus.release_pulse == 4'b1111) saw_all_rel = 1'b1;
        cyc++;
    endtask

    task automatic run(int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    // Clocks until press[ch] is seen, or -1 if the bound expires.
    task automatic run_until_press(int ch, int bound, output int lat);
        lat = -1;
        for (int k = 1; k <= bound; k++) begin
            cycle();
            if (bus.press[ch]) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        int          lat;
        int          p0;
        int unsigned b;
        for (int ch = 0; ch < N_CH; ch++) begin
            since[ch] = -1; press_edge[ch] = -1;
            press_cnt[ch] = 0; rel_cnt[ch] = 0; long_cnt[ch] = 0; hi_cnt[ch] = 0;
            last_press_cyc[ch] = 0; last_long_cyc[ch] = 0;
        end
        out_m       = '0;
        rst         = 1'b1;
        bus.btn_in  = '0;
        bus.tick_mf = 1'b0;

        // Reset state, including inputs driven high during reset.
        run(2);
        bus.btn_in = 4'b1111;
        run(2);
        bus.btn_in = '0;
        run(1);
        rst = 1'b0;
        run(4);

        // Clean press on channel 0: 2 sync + 1 + 4 ticks at one tick per 2 clocks.
        bus.btn_in = 4'b0001;
        run_until_press(0, 30, lat);
        chk_int("clean_press_latency_in_10_11", int'(lat >= 10 && lat <= 11), 1);
        run(5);
        chk_int("clean_press_count", press_cnt[0], 1);
        chk_int("clean_others_quiet", press_cnt[1] + press_cnt[2] + press_cnt[3], 0);
        bus.btn_in = 4'b0000;
        run(15);
        chk_int("clean_release_count", rel_cnt[0], 1);

        // Bounce on channel 1 with one-tick gaps, then hold.
        bus.btn_in[1] = 1'b1; run(2);
        bus.btn_in[1] = 1'b0; run(2);
        bus.btn_in[1] = 1'b1;
        run_until_press(1, 30, lat);
        chk_int("bounce_latency_from_last_edge", int'(lat >= 10 && lat <= 11), 1);
        run(6);
        chk_int("bounce_single_press", press_cnt[1], 1);
        bus.btn_in[1] = 1'b0;
        run(15);

        // Short glitch on channel 2: three ticks high, never accepted.
        bus.btn_in[2] = 1'b1; run(6);
        bus.btn_in[2] = 1'b0; run(20);
        chk_int("glitch_no_press", press_cnt[2], 0);
        chk_int("glitch_no_release", rel_cnt[2], 0);
        chk_int("glitch_btn_out_low", hi_cnt[2], 0);

        // Simultaneous press and release on all channels.
        bus.btn_in = 4'b1111; run(15);
        chk_int("simul_press_all", int'(saw_all_press), 1);
        bus.btn_in = 4'b0000; run(15);
        chk_int("simul_release_all", int'(saw_all_rel), 1);

        // Reset after two ticks of a pending press discards progress.
        p0 = press_cnt[0];
        bus.btn_in[0] = 1'b1;
        run(7);
        rst = 1'b1; run(1);
        rst = 1'b0;
        chk_int("rst_mid_no_pulse", press_cnt[0], p0);
        run_until_press(0, 30, lat);
        chk_int("rst_full_restart_latency", int'(lat >= 10 && lat <= 11), 1);
        chk_int("rst_single_press_after", press_cnt[0], p0 + 1);
        bus.btn_in[0] = 1'b0;
        run(15);

        // Long hold on channel 3 for more than 20 ticks.
        bus.btn_in[3] = 1'b1;
        run_until_press(3, 30, lat);
        chk_int("long_press_seen", int'(lat > 0), 1);
        run(45);
`ifdef ANTI_BOUNCE_LONG_PRESS_EN
        chk_int("long_single_pulse", long_cnt[3], 1);
        chk_int("long_delay_20clk", last_long_cyc[3] - last_press_cyc[3], 20);
`else
        chk_int("long_absent", long_cnt[0] + long_cnt[1] + long_cnt[2] + long_cnt[3], 0);
`endif
        bus.btn_in[3] = 1'b0;
        run(15);

        // Random toggling with occasional reset, checked every clock by the model.
        for (int k = 0; k < 700; k++) begin
            if ($urandom_range(11) == 0) begin
                b = $urandom_range(N_CH - 1);
                bus.btn_in[b] = ~bus.btn_in[b];
            end
            rst = ($urandom_range(249) == 0);
            cycle();
        end
        rst = 1'b0;
        bus.btn_in = '0;
        run(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
